// File: rtl/ysyx_24110006_mem_arb_pkg.sv
// Shared types and defaults for the IFU/LSU memory arbiter.
// Holds the FSM state encoding and the owner tag used by the arbiter.
package ysyx_24110006_mem_arb_pkg;

    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int DEFAULT_ADDR_W       = 32;
    localparam int MASK_W               = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_24110006_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Used to count how many LSU grants in a row have been made while the IFU waited.
module ysyx_24110006_sat_cnt #(
    parameter int LIMIT = 4,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_full
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && (count_q != LIM)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_full = (count_q == LIM);

endmodule

// File: rtl/ysyx_24110006_mem_arb.sv
// Two-master (IFU, LSU) arbiter onto a single-outstanding memory port.
// LSU wins by default; the IFU is forced through after STARVE_LIMIT consecutive LSU wins.
module ysyx_24110006_mem_arb
    import ysyx_24110006_mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int ADDR_W       = DEFAULT_ADDR_W
) (
    input  logic              i_clock,
    input  logic              i_reset,

    input  logic              i_ifu_req,
    input  logic [ADDR_W-1:0] i_ifu_addr,
    output logic              o_ifu_gnt,
    output logic              o_ifu_rvalid,
    output logic [ADDR_W-1:0] o_ifu_rdata,
    output logic              o_ifu_err,

    input  logic              i_lsu_req,
    input  logic              i_lsu_wen,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [ADDR_W-1:0] i_lsu_wdata,
    input  logic [MASK_W-1:0] i_lsu_wmask,
    output logic              o_lsu_gnt,
    output logic              o_lsu_rvalid,
    output logic [ADDR_W-1:0] o_lsu_rdata,
    output logic              o_lsu_err,

    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [ADDR_W-1:0] o_mem_wdata,
    output logic [MASK_W-1:0] o_mem_wmask,
    input  logic              i_mem_rvalid,
    input  logic [ADDR_W-1:0] i_mem_rdata,
    input  logic              i_mem_err,

    input  logic              i_flush,
    output logic              o_busy
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              wen_q, wen_d;

    logic in_idle;
    logic starve_full;
    logic ifu_pri;
    logic grant_ifu;
    logic grant_lsu;
    logic resp_fire;

    // A flush blocks the IFU in the same cycle; priority only flips when the IFU can actually take it.
    always_comb begin
        in_idle   = (state_q == ST_IDLE) && i_reset;
        ifu_pri   = starve_full && i_ifu_req && !i_flush;
        grant_lsu = in_idle && i_lsu_req && !ifu_pri;
        grant_ifu = in_idle && i_ifu_req && !i_flush && !grant_lsu;
        resp_fire = (state_q == ST_RESP) && i_mem_rvalid;
    end

    ysyx_24110006_sat_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clr   (grant_ifu || (in_idle && !i_ifu_req)),
        .i_inc   (grant_lsu && i_ifu_req),
        .o_full  (starve_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_ifu || grant_lsu) state_d = ST_ADDR;
            ST_ADDR: if (i_mem_ready)            state_d = ST_RESP;
            ST_RESP: if (i_mem_rvalid)           state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        owner_d = owner_q;
        drop_d  = drop_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        if (grant_lsu) begin
            owner_d = OWN_LSU;
            addr_d  = i_lsu_addr;
            wen_d   = i_lsu_wen;
            wdata_d = i_lsu_wdata;
            wmask_d = i_lsu_wmask;
        end else if (grant_ifu) begin
            owner_d = OWN_IFU;
            addr_d  = i_ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
        end
        // A flushed fetch still runs to completion on the bus; only its response is swallowed.
        if (resp_fire) begin
            drop_d = 1'b0;
        end else if ((state_q != ST_IDLE) && (owner_q == OWN_IFU) && i_flush) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge i_clock) begin
        addr_q  <= addr_d;
        wen_q   <= wen_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
    end

    // Memory side: o_mem_valid holds with stable fields until i_mem_ready; one i_mem_rvalid ends the transfer.
    always_comb begin
        o_busy       = (state_q != ST_IDLE);
        o_ifu_gnt    = grant_ifu;
        o_lsu_gnt    = grant_lsu;
        o_mem_valid  = (state_q == ST_ADDR);
        o_mem_wen    = o_mem_valid && wen_q;
        o_mem_addr   = o_mem_valid ? addr_q  : '0;
        o_mem_wdata  = o_mem_valid ? wdata_q : '0;
        o_mem_wmask  = o_mem_valid ? wmask_q : '0;
        o_ifu_rvalid = resp_fire && (owner_q == OWN_IFU) && !drop_q && !i_flush;
        o_lsu_rvalid = resp_fire && (owner_q == OWN_LSU);
        o_ifu_rdata  = o_ifu_rvalid ? i_mem_rdata : '0;
        o_lsu_rdata  = o_lsu_rvalid ? i_mem_rdata : '0;
        o_ifu_err    = o_ifu_rvalid && i_mem_err;
        o_lsu_err    = o_lsu_rvalid && i_mem_err;
    end

endmodule

// File: tb/tb_ysyx_24110006_mem_arb.sv
// Randomised bench for the IFU/LSU memory arbiter.
// The driver plays both masters and the memory, and queues the outputs it expects for every cycle.
module tb_ysyx_24110006_mem_arb;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req, lsu_req, lsu_wen, flush;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_ready, mem_rvalid, mem_err;
    logic        o_ifu_gnt, o_ifu_rvalid, o_ifu_err;
    logic        o_lsu_gnt, o_lsu_rvalid, o_lsu_err;
    logic [31:0] o_ifu_rdata, o_lsu_rdata;
    logic        o_mem_valid, o_mem_wen, o_busy;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wmask;

    always #5 clk = ~clk;

    ysyx_24110006_mem_arb #(.STARVE_LIMIT(LIM), .ADDR_W(32)) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_ifu_req    (ifu_req),
        .i_ifu_addr   (ifu_addr),
        .o_ifu_gnt    (o_ifu_gnt),
        .o_ifu_rvalid (o_ifu_rvalid),
        .o_ifu_rdata  (o_ifu_rdata),
        .o_ifu_err    (o_ifu_err),
        .i_lsu_req    (lsu_req),
        .i_lsu_wen    (lsu_wen),
        .i_lsu_addr   (lsu_addr),
        .i_lsu_wdata  (lsu_wdata),
        .i_lsu_wmask  (lsu_wmask),
        .o_lsu_gnt    (o_lsu_gnt),
        .o_lsu_rvalid (o_lsu_rvalid),
        .o_lsu_rdata  (o_lsu_rdata),
        .o_lsu_err    (o_lsu_err),
        .o_mem_valid  (o_mem_valid),
        .i_mem_ready  (mem_ready),
        .o_mem_wen    (o_mem_wen),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wmask  (o_mem_wmask),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .i_mem_err    (mem_err),
        .i_flush      (flush),
        .o_busy       (o_busy)
    );

    typedef struct packed {
        logic        ig;
        logic        lg;
        logic        mv;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] md;
        logic [3:0]  mm;
        logic        iv;
        logic [31:0] ir;
        logic        ie;
        logic        lv;
        logic [31:0] lr;
        logic        le;
        logic        busy;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state: owner codes 0 = none, 1 = IFU, 2 = LSU.
    int          starve = 0;
    bit          drop   = 0;
    int          cur_owner = 0;
    logic        cur_wen;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wmask;

    // Monitor / scoreboard.
    always @(negedge clk) begin
        obs_t act;
        obs_t exp;
        cyc++;
        if (exp_q.size() > 0) begin
            act.ig = o_ifu_gnt;    act.lg = o_lsu_gnt;
            act.mv = o_mem_valid;  act.mw = o_mem_wen;
            act.ma = o_mem_addr;   act.md = o_mem_wdata;  act.mm = o_mem_wmask;
            act.iv = o_ifu_rvalid; act.ir = o_ifu_rdata;  act.ie = o_ifu_err;
            act.lv = o_lsu_rvalid; act.lr = o_lsu_rdata;  act.le = o_lsu_err;
            act.busy = o_busy;
            exp = exp_q.pop_front();
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL cycle_outputs @%0d: got %h expected %h (gnt i/l %b%b/%b%b rv i/l %b%b/%b%b mv %b/%b)",
                         cyc, act, exp, act.ig, act.lg, exp.ig, exp.lg,
                         act.iv, act.lv, exp.iv, exp.lv, act.mv, exp.mv);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_reqs();
        ifu_req   = 1'($urandom_range(0, 1));
        lsu_req   = 1'($urandom_range(0, 1));
        lsu_wen   = 1'($urandom_range(0, 1));
        ifu_addr  = $urandom;
        lsu_addr  = $urandom;
        lsu_wdata = $urandom;
        lsu_wmask = 4'($urandom);
    endtask

    // One idle cycle: present requests, predict the winner from the arbitration rules.
    task automatic free_cycle(input bit ireq, input logic [31:0] iaddr, input bit lreq,
                              input bit lwen, input logic [31:0] laddr, input logic [31:0] lwdata,
                              input logic [3:0] lwmask, input bit fl, output int win);
        obs_t e = '0;
        step();
        ifu_req = ireq;  ifu_addr = iaddr;
        lsu_req = lreq;  lsu_wen = lwen;  lsu_addr = laddr;  lsu_wdata = lwdata;  lsu_wmask = lwmask;
        flush = fl;
        mem_ready = 1'b1;  mem_rvalid = 1'b1;  mem_rdata = $urandom;  mem_err = 1'b1;
        if (lreq && !(starve == LIM && ireq && !fl)) win = 2;
        else if (ireq && !fl)                        win = 1;
        else                                         win = 0;
        if (!ireq || win == 1)            starve = 0;
        else if (win == 2 && starve < LIM) starve++;
        e.ig = (win == 1);
        e.lg = (win == 2);
        exp_q.push_back(e);
        if (win == 1) begin
            cur_owner = 1; cur_wen = 1'b0; cur_addr = iaddr; cur_wdata = '0; cur_wmask = '0;
        end else if (win == 2) begin
            cur_owner = 2; cur_wen = lwen; cur_addr = laddr; cur_wdata = lwdata; cur_wmask = lwmask;
        end
    endtask

    // Bus side of a granted transfer: d1 cycles of stall before ready, d2 cycles before the response.
    task automatic run_txn(input int d1, input int d2, input logic [31:0] rdata, input bit err,
                           input int fl_at, input bit rnd_fl);
        obs_t e;
        bit   fl;
        drop = 0;
        for (int k = 0; k <= d1; k++) begin
            step();
            rand_reqs();
            fl = (k == fl_at) || (rnd_fl && $urandom_range(0, 5) == 0);
            flush = fl;
            mem_ready = (k == d1);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            mem_err = 1'($urandom_range(0, 1));
            e = '0;
            e.mv = 1'b1; e.mw = cur_wen; e.ma = cur_addr; e.md = cur_wdata; e.mm = cur_wmask;
            e.busy = 1'b1;
            exp_q.push_back(e);
            if (fl && cur_owner == 1) drop = 1;
        end
        for (int k = 0; k <= d2; k++) begin
            step();
            rand_reqs();
            fl = (d1 + 1 + k == fl_at) || (rnd_fl && $urandom_range(0, 5) == 0);
            flush = fl;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rvalid = (k == d2);
            mem_rdata = (k == d2) ? rdata : $urandom;
            mem_err = (k == d2) ? err : 1'($urandom_range(0, 1));
            e = '0;
            e.busy = 1'b1;
            if (k == d2) begin
                if (cur_owner == 2) begin
                    e.lv = 1'b1; e.lr = rdata; e.le = err;
                end else if (!(drop || fl)) begin
                    e.iv = 1'b1; e.ir = rdata; e.ie = err;
                end
            end
            exp_q.push_back(e);
            if (fl && cur_owner == 1) drop = 1;
        end
    endtask

    // Hold reset for n cycles with requests and responses pulled high; everything must read zero.
    task automatic do_reset(input int n);
        obs_t z = '0;
        for (int k = 0; k < n; k++) begin
            step();
            rst_n = 1'b0;
            ifu_req = 1'b1;  lsu_req = 1'b1;  flush = 1'b0;
            mem_ready = 1'b1;  mem_rvalid = 1'b1;  mem_err = 1'b1;
            if (k == 0) begin
                #1;
                n_checks++;
                if (o_mem_valid !== 1'b0 || o_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_async: mem_valid=%b busy=%b required 0 0", o_mem_valid, o_busy);
                end
            end
            exp_q.push_back(z);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        ifu_req = 1'b0;  lsu_req = 1'b0;  flush = 1'b0;
        mem_ready = 1'b0;  mem_rvalid = 1'b0;  mem_err = 1'b0;
        starve = 0;
        drop = 0;
    endtask

    initial begin
        int   w;
        obs_t e;
        ifu_req = 0; lsu_req = 0; lsu_wen = 0; flush = 0;
        ifu_addr = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
        do_reset(3);

        // LSU load, ready at once, response next cycle.
        free_cycle(0, 32'h0, 1, 0, 32'h8000_0010, 32'h0, 4'hf, 0, w);
        run_txn(0, 0, 32'hDEAD_BEEF, 0, -1, 0);

        // Both masters always requesting: starvation guard lets the IFU through every fifth grant.
        for (int i = 0; i < 10; i++) begin
            free_cycle(1, 32'h3000_0000 + 32'(i * 4), 1, 0, 32'h8000_1000 + 32'(i * 4),
                       $urandom, 4'hf, 0, w);
            run_txn(0, 0, $urandom, 0, -1, 0);
        end

        // Flushed fetch: flush lands in the response cycle, then a flush in idle blocks an IFU grant.
        free_cycle(1, 32'h3000_0000, 0, 0, 32'h0, 32'h0, 4'h0, 0, w);
        run_txn(0, 0, 32'h0000_1234, 0, 1, 0);
        free_cycle(1, 32'h3000_0004, 0, 0, 32'h0, 32'h0, 4'h0, 1, w);
        free_cycle(1, 32'h3000_0004, 0, 0, 32'h0, 32'h0, 4'h0, 0, w);
        run_txn(0, 1, 32'h0000_5678, 0, -1, 0);

        // Store stalled by five cycles of ready low.
        free_cycle(0, 32'h0, 1, 1, 32'h8000_0100, 32'hA5A5_A5A5, 4'b0011, 0, w);
        run_txn(5, 0, $urandom, 0, -1, 0);

        // Fetch with an access fault; flush during an LSU transfer has no effect.
        free_cycle(1, 32'h3000_0008, 0, 0, 32'h0, 32'h0, 4'h0, 0, w);
        run_txn(0, 0, 32'hBAD0_0BAD, 1, -1, 0);
        free_cycle(0, 32'h0, 1, 0, 32'h8000_0200, 32'h0, 4'hf, 0, w);
        run_txn(1, 1, 32'h0BAD_F00D, 1, 1, 0);

        // Reset in the middle of an address phase; the abandoned response must never appear.
        free_cycle(0, 32'h0, 1, 0, 32'h8000_0300, 32'h0, 4'hf, 0, w);
        step();
        mem_ready = 1'b0;  mem_rvalid = 1'b1;  lsu_req = 1'b0;
        e = '0;
        e.mv = 1'b1; e.mw = cur_wen; e.ma = cur_addr; e.md = cur_wdata; e.mm = cur_wmask; e.busy = 1'b1;
        exp_q.push_back(e);
        do_reset(2);
        for (int i = 0; i < 3; i++) free_cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, w);

        // Random traffic with random stalls, faults and flushes.
        for (int i = 0; i < 300; i++) begin
            free_cycle(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0,
                       1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                       $urandom_range(0, 7) == 0, w);
            if (w != 0) run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                                1'($urandom_range(0, 1)), -1, 1);
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24110006_mem_arb.md
YSYX_24110006_MEM_ARB -- requirements
Module: ysyx_24110006_mem_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive LSU grants while IFU waits before IFU is forced priority.
REQ-002 SHALL have parameter ADDR_W, default 32: address/data width.
REQ-003 SHALL have ports: i_clock  in  1  sole clock, rising edge.
REQ-004 SHALL have port: i_reset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have IFU ports: i_ifu_req in 1 fetch request; i_ifu_addr in 32 fetch address; o_ifu_gnt out 1 request accepted; o_ifu_rvalid out 1 fetch data valid; o_ifu_rdata out 32 fetch data; o_ifu_err out 1 fetch access fault.
REQ-006 SHALL have LSU ports: i_lsu_req in 1; i_lsu_wen in 1 store=1/load=0; i_lsu_addr in 32; i_lsu_wdata in 32; i_lsu_wmask in 4; o_lsu_gnt out 1; o_lsu_rvalid out 1 load data / store done; o_lsu_rdata out 32; o_lsu_err out 1.
REQ-007 SHALL have memory ports: o_mem_valid out 1; i_mem_ready in 1; o_mem_wen out 1; o_mem_addr out 32; o_mem_wdata out 32; o_mem_wmask out 4; i_mem_rvalid in 1 response; i_mem_rdata in 32; i_mem_err in 1 response fault.
REQ-008 SHALL have i_flush in 1 (pipeline redirect) and o_busy out 1 (state != IDLE).

Function
REQ-009 SHALL implement FSM IDLE -> ADDR -> RESP -> IDLE, one outstanding transaction maximum.
REQ-010 In IDLE, SHALL grant LSU when i_lsu_req=1, unless starve counter == STARVE_LIMIT and i_ifu_req=1, then grant IFU.
REQ-011 Grant SHALL be a one-cycle o_*_gnt pulse in IDLE; requester fields SHALL be latched same edge; owner register records IFU/LSU.
REQ-012 In ADDR, o_mem_valid=1 with latched addr/wen/wdata/wmask held stable until i_mem_ready=1; then -> RESP.
REQ-013 In RESP, on i_mem_rvalid=1 SHALL pulse owner's o_*_rvalid one cycle with rdata=i_mem_rdata, err=i_mem_err; -> IDLE same edge.
REQ-014 Non-owner o_*_rvalid, o_*_err SHALL be 0; o_*_rdata SHALL be 0 when rvalid=0.
REQ-015 Starve counter SHALL increment (saturating at STARVE_LIMIT) on each LSU grant with i_ifu_req=1, clear on any IFU grant or i_ifu_req=0 in IDLE.
REQ-016 i_flush=1 while owner=IFU in ADDR/RESP SHALL set a drop flag; transaction completes on the bus, o_ifu_rvalid suppressed; flag clears on return to IDLE.
REQ-017 i_flush SHALL NOT affect LSU-owned transactions and SHALL block IFU grant in the same IDLE cycle.
REQ-018 i_mem_rvalid outside RESP SHALL be ignored; i_mem_ready outside ADDR SHALL be ignored.
REQ-019 Minimum latency req->rvalid SHALL be 3 cycles (gnt, ADDR with ready, RESP with rvalid); back-to-back grant allowed in IDLE cycle after RESP exit.
REQ-020 Stores SHALL complete only via i_mem_rvalid (write response), rdata forwarded but meaningless.

Reset
REQ-021 Reset asserted SHALL asynchronously force state=IDLE, owner=IFU, starve=0, drop=0, all outputs 0.
REQ-022 Reset mid-transaction SHALL abandon it; no rvalid pulse after deassertion for the abandoned request.
REQ-023 Latched data registers need no reset; outputs derived from them SHALL be gated by state.

Structure
REQ-024 State encoding and owner enum SHALL live in shared package/config header with other common config.
REQ-025 Starvation counter MAY be sub-module ysyx_24110006_sat_cnt; everything else flat.

Verification
REQ-026 LSU load 0x8000_0010, ready at once, rvalid next cycle with 0xDEAD_BEEF -> o_lsu_rvalid one pulse, rdata 0xDEAD_BEEF, o_ifu_rvalid 0.
REQ-027 Both request every cycle, STARVE_LIMIT=4 -> grant order LSU x4, IFU, LSU x4, IFU.
REQ-028 IFU fetch 0x3000_0000, i_flush in RESP, rvalid 0x1234 -> no o_ifu_rvalid, state returns IDLE, next IFU grant works.
REQ-029 LSU store wdata 0xA5A5_A5A5 mask 4'b0011, i_mem_ready low 5 cycles -> o_mem_valid/addr/wdata/wmask stable all 5 cycles.
REQ-030 i_mem_err=1 on IFU response -> o_ifu_err=1 with o_ifu_rvalid pulse; i_reset low mid-ADDR -> o_mem_valid 0 immediately, no response pulse afterwards.
